// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, access
// length codes and requester port identifiers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_MA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Counts consecutive port-1 grants taken while fetch waits and raises the
// force-port-0 flag once the limit is reached.
module arb_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic req0,
  input  logic abort0,
  input  logic grant0,
  input  logic grant1,
  output logic force0
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] SAT = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (idle) begin
      // An aborting fetch is not really waiting, so it does not accrue credit.
      if (grant0 || !req0) begin
        cnt_reg <= '0;
      end else if (grant1 && !abort0 && (cnt_reg != SAT)) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign force0 = req0 && (cnt_reg == SAT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory interface between instruction fetch (port 0, read-only)
// and the memory-access stage (port 1); each grant runs access then ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MADDR_L  = 32,
  parameter int DATA_L   = 32,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [MADDR_L-1:0] addr0,
  input  logic [1:0]         rlen0,
  input  logic               abort0,
  output logic               ack0,
  output logic [DATA_L-1:0]  rdata0,
  input  logic               req1,
  input  logic               we1,
  input  logic [MADDR_L-1:0] addr1,
  input  logic [1:0]         len1,
  input  logic [DATA_L-1:0]  wdata1,
  output logic               ack1,
  output logic [DATA_L-1:0]  rdata1,
  input  logic [DATA_L-1:0]  mem_din,
  output logic [DATA_L-1:0]  mem_dout,
  output logic [MADDR_L-1:0] mem_raddr,
  output logic [MADDR_L-1:0] mem_waddr,
  output logic               mem_re,
  output logic               mem_we,
  output logic [1:0]         mem_rlen,
  output logic [1:0]         mem_wlen,
  output logic               busy,
  output logic               owner
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               owner_reg, cancel_reg, re_reg, we_reg;
  logic [MADDR_L-1:0] raddr_reg, waddr_reg;
  logic [1:0]         rlen_reg, wlen_reg;
  logic [DATA_L-1:0]  dout_reg, rdata0_reg, rdata1_reg;
  logic               idle, grant0, grant1, force0;

  assign idle   = (state_reg == ST_IDLE);
  assign grant1 = idle && req1 && !force0;
  assign grant0 = idle && !grant1 && req0 && !abort0;

  arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .idle   (idle),
    .req0   (req0),
    .abort0 (abort0),
    .grant0 (grant0),
    .grant1 (grant1),
    .force0 (force0)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // ack0 also honours abort0 in the RESP cycle itself, hence combinational.
  always_comb begin
    state_next = state_reg;
    ack0       = 1'b0;
    ack1       = 1'b0;
    busy       = !idle;
    case (state_reg)
      ST_IDLE:   if (grant0 || grant1) state_next = ST_ACCESS;
      ST_ACCESS: if (cnt_reg == '0) state_next = ST_RESP;
      ST_RESP: begin
        state_next = ST_IDLE;
        ack0 = (owner_reg == PORT_IF) && !cancel_reg && !abort0;
        ack1 = (owner_reg == PORT_MA);
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg    <= '0;
      owner_reg  <= PORT_IF;
      re_reg     <= 1'b0;
      we_reg     <= 1'b0;
      raddr_reg  <= '0;
      waddr_reg  <= '0;
      rlen_reg   <= '0;
      wlen_reg   <= '0;
      dout_reg   <= '0;
      rdata0_reg <= '0;
      rdata1_reg <= '0;
    end else if (grant0 || grant1) begin
      owner_reg <= grant1 ? PORT_MA : PORT_IF;
      cnt_reg   <= CNT_LOAD;
      if (grant1 && we1) begin
        we_reg    <= 1'b1;
        waddr_reg <= addr1;
        wlen_reg  <= len1;
        dout_reg  <= wdata1;
      end else begin
        re_reg    <= 1'b1;
        raddr_reg <= grant1 ? addr1 : addr0;
        rlen_reg  <= grant1 ? len1 : rlen0;
      end
    end else if (state_reg == ST_ACCESS) begin
      if (cnt_reg == '0) begin
        re_reg <= 1'b0;
        we_reg <= 1'b0;
        if (re_reg) begin
          if (owner_reg == PORT_MA) rdata1_reg <= mem_din;
          else                      rdata0_reg <= mem_din;
        end
      end else begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cancel_reg <= 1'b0;
    else if (idle)                             cancel_reg <= 1'b0;
    else if (abort0 && owner_reg == PORT_IF)   cancel_reg <= 1'b1;
  end

  assign owner     = owner_reg;
  assign mem_re    = re_reg;
  assign mem_we    = we_reg;
  assign mem_raddr = raddr_reg;
  assign mem_waddr = waddr_reg;
  assign mem_rlen  = rlen_reg;
  assign mem_wlen  = wlen_reg;
  assign mem_dout  = dout_reg;
  assign rdata0    = rdata0_reg;
  assign rdata1    = rdata1_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table, contention/abort/reset sequences and a randomized
// run against a transaction-timeline reference model.
module tb_mem_port_arbiter;

  localparam int L  = 2;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, abort0, ack0, req1, we1, ack1;
  logic [31:0] addr0, addr1, wdata1, rdata0, rdata1;
  logic [1:0]  rlen0, len1, mem_rlen, mem_wlen;
  logic [31:0] mem_din, mem_dout, mem_raddr, mem_waddr;
  logic        mem_re, mem_we, busy, owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  assign mem_din = memval(mem_raddr);

  mem_port_arbiter #(.MADDR_L(32), .DATA_L(32), .MEM_LAT(L), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .rlen0(rlen0), .abort0(abort0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .len1(len1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rlen(mem_rlen), .mem_wlen(mem_wlen), .busy(busy), .owner(owner)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ctl = {mem_re, mem_we, ack0, ack1, busy, owner}
  typedef struct {
    logic        r0, ab;
    logic [31:0] a0;
    logic        r1, w1;
    logic [5:0]  ctl;
    logic [31:0] ra, wa, rd0, rd1;
  } row_t;

  localparam int NROWS = 19;
  row_t tbl [NROWS];

  function automatic row_t mk(input logic r0, input logic ab, input logic [31:0] a0,
                              input logic r1, input logic w1, input logic [5:0] ctl,
                              input logic [31:0] ra, input logic [31:0] wa,
                              input logic [31:0] rd0, input logic [31:0] rd1);
    row_t r;
    r.r0 = r0; r.ab = ab; r.a0 = a0; r.r1 = r1; r.w1 = w1; r.ctl = ctl;
    r.ra = ra; r.wa = wa; r.rd0 = rd0; r.rd1 = rd1;
    return r;
  endfunction

  task automatic fill_table();
    logic [31:0] db, m3, m2;
    db = 32'hDEADBEEF; m3 = memval(32'h300); m2 = memval(32'h2004);
    // port-0 read of 0x100
    tbl[0]  = mk(1, 0, 32'h100, 0, 0, 6'b000000, 0,        0,        0,  0);
    tbl[1]  = mk(1, 0, 32'h100, 0, 0, 6'b100010, 32'h100,  0,        0,  0);
    tbl[2]  = mk(1, 0, 32'h100, 0, 0, 6'b100010, 32'h100,  0,        0,  0);
    tbl[3]  = mk(0, 0, 32'h100, 0, 0, 6'b001010, 32'h100,  0,        db, 0);
    tbl[4]  = mk(0, 0, 0,       0, 0, 6'b000000, 32'h100,  0,        db, 0);
    // port-1 write to 0x2004
    tbl[5]  = mk(0, 0, 0,       1, 1, 6'b000000, 32'h100,  0,        db, 0);
    tbl[6]  = mk(0, 0, 0,       1, 1, 6'b010011, 32'h100,  32'h2004, db, 0);
    tbl[7]  = mk(0, 0, 0,       1, 1, 6'b010011, 32'h100,  32'h2004, db, 0);
    tbl[8]  = mk(0, 0, 0,       0, 0, 6'b000111, 32'h100,  32'h2004, db, 0);
    tbl[9]  = mk(0, 0, 0,       0, 0, 6'b000001, 32'h100,  32'h2004, db, 0);
    // port-0 read of 0x300 aborted in first access cycle, port-1 read pending
    tbl[10] = mk(1, 0, 32'h300, 0, 0, 6'b000001, 32'h100,  32'h2004, db, 0);
    tbl[11] = mk(1, 1, 32'h300, 1, 0, 6'b100010, 32'h300,  32'h2004, db, 0);
    tbl[12] = mk(0, 0, 32'h300, 1, 0, 6'b100010, 32'h300,  32'h2004, db, 0);
    tbl[13] = mk(0, 0, 0,       1, 0, 6'b000010, 32'h300,  32'h2004, m3, 0);
    tbl[14] = mk(0, 0, 0,       1, 0, 6'b000000, 32'h300,  32'h2004, m3, 0);
    tbl[15] = mk(0, 0, 0,       1, 0, 6'b100011, 32'h2004, 32'h2004, m3, 0);
    tbl[16] = mk(0, 0, 0,       1, 0, 6'b100011, 32'h2004, 32'h2004, m3, 0);
    tbl[17] = mk(0, 0, 0,       0, 0, 6'b000111, 32'h2004, 32'h2004, m3, m2);
    tbl[18] = mk(0, 0, 0,       0, 0, 6'b000001, 32'h2004, 32'h2004, m3, m2);
  endtask

  task automatic idle_inputs();
    req0 = 0; abort0 = 0; req1 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; rlen0 = 0; len1 = 0; wdata1 = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < NROWS; i++) begin
      @(posedge clk); #1;
      req0 = tbl[i].r0; abort0 = tbl[i].ab; addr0 = tbl[i].a0;
      req1 = tbl[i].r1; we1 = tbl[i].w1;
      addr1 = 32'h2004; len1 = 2'd1; wdata1 = 32'h0000ABCD; rlen0 = 2'd2;
      @(negedge clk);
      check($sformatf("%s_ctl_row%0d", tag, i),
            64'({mem_re, mem_we, ack0, ack1, busy, owner}), 64'(tbl[i].ctl));
      check($sformatf("%s_addr_row%0d", tag, i),
            {mem_raddr, mem_waddr}, {tbl[i].ra, tbl[i].wa});
      check($sformatf("%s_rdata_row%0d", tag, i), {rdata0, rdata1}, {tbl[i].rd0, tbl[i].rd1});
      if (i == 7)
        check($sformatf("%s_wr_data", tag), 64'({mem_wlen, mem_dout}), 64'({2'd1, 32'h0000ABCD}));
      if (i == 2)
        check($sformatf("%s_rlen", tag), 64'(mem_rlen), 64'(2'd2));
    end
  endtask

  // Reference model state: k is the cycle offset within the active transaction
  // (0 = free, 1..L = memory access, L+1 = acknowledge).
  int          k, starve;
  logic        m_port, m_we, m_ab;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_len;
  logic        e_owner;
  logic [31:0] e_raddr, e_waddr, e_dout, e_rd0, e_rd1;
  logic [1:0]  e_rlen, e_wlen;

  task automatic model_reset();
    k = 0; starve = 0; m_port = 0; m_we = 0; m_ab = 0;
    m_addr = 0; m_wdata = 0; m_len = 0; e_owner = 0;
    e_raddr = 0; e_waddr = 0; e_dout = 0; e_rd0 = 0; e_rd1 = 0; e_rlen = 0; e_wlen = 0;
  endtask

  task automatic model_compare();
    logic in_acc, in_resp, e_ack0, e_ack1;
    in_acc  = (k >= 1) && (k <= L);
    in_resp = (k == L + 1);
    e_ack0  = in_resp && !m_port && !(m_ab || abort0);
    e_ack1  = in_resp && m_port;
    check("rnd_ctl", 64'({busy, owner, mem_re, mem_we, ack0, ack1}),
          64'({k != 0, e_owner, in_acc && !m_we, in_acc && m_we, e_ack0, e_ack1}));
    check("rnd_rd_port", 64'({mem_rlen, mem_raddr}), 64'({e_rlen, e_raddr}));
    check("rnd_wr_port", 64'({mem_wlen, mem_waddr}), 64'({e_wlen, e_waddr}));
    check("rnd_dout", 64'(mem_dout), 64'(e_dout));
    check("rnd_rdata", {rdata0, rdata1}, {e_rd0, e_rd1});
    if (e_ack0 || e_ack1)
      $display("txn port=%0d we=%0d addr=%h len=%0d", m_port, m_we, m_addr, m_len);
  endtask

  task automatic model_step();
    logic g0, g1;
    if (k == 0) begin
      g1 = req1 && !(req0 && starve == MW);
      g0 = !g1 && req0 && !abort0;
      if (g0 || !req0) starve = 0;
      else if (g1 && !abort0 && starve < MW) starve++;
      if (g0 || g1) begin
        m_port = g1; m_we = g1 && we1;
        m_addr = g1 ? addr1 : addr0; m_len = g1 ? len1 : rlen0;
        m_wdata = wdata1; m_ab = 0; e_owner = g1;
        if (m_we) begin e_waddr = m_addr; e_wlen = m_len; e_dout = m_wdata; end
        else begin e_raddr = m_addr; e_rlen = m_len; end
        k = 1;
      end
    end else if (k <= L) begin
      if (!m_port && abort0) m_ab = 1;
      if (k == L && !m_we) begin
        if (m_port) e_rd1 = memval(m_addr);
        else        e_rd0 = memval(m_addr);
      end
      k++;
    end else begin
      k = 0;
    end
  endtask

  initial begin
    int order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int n;
    idle_inputs();
    rst = 0;
    #1;
    check("reset_outputs",
          64'({mem_re, mem_we, ack0, ack1, busy, owner}), 64'(0));
    check("reset_data", {mem_raddr, mem_waddr}, 64'(0));
    fill_table();
    do_reset();
    run_table("tbl");

    // Contention: both ports request continuously.
    @(posedge clk); #1;
    req0 = 1; req1 = 1; we1 = 0; abort0 = 0;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        check($sformatf("grant_order_%0d", n), 64'({ack1, ack0, owner}),
              64'({order[n] == 1, order[n] == 0, order[n] == 1}));
        $display("txn contention ack port=%0d", ack1);
        n++;
      end
    end
    check("contention_ack_count", 64'(n), 64'(10));
    idle_inputs();

    // Asynchronous reset in the middle of an access.
    do_reset();
    req0 = 1; addr0 = 32'h100; rlen0 = 2'd2;
    @(posedge clk); #1;
    req0 = 0;
    check("pre_reset_re", 64'({mem_re, busy}), 64'(2'b11));
    #3 rst = 0;
    #1;
    check("async_reset_drop", 64'({mem_re, mem_we, busy}), 64'(0));
    @(posedge clk); #1;
    rst = 1;
    run_table("post_rst");

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      req0   = ($urandom_range(9) < 6);
      abort0 = ($urandom_range(9) == 0);
      req1   = ($urandom_range(9) < 5);
      we1    = $urandom_range(1) == 1;
      addr0  = $urandom();
      addr1  = $urandom();
      rlen0  = 2'($urandom_range(3));
      len1   = 2'($urandom_range(3));
      wdata1 = $urandom();
      @(negedge clk);
      model_compare();
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
